// File: rtl/ifu_prefetch_queue.sv
// ifu_prefetch_queue: PC generator feeding a DEPTH-entry instruction prefetch queue with decode
// back-pressure, redirect flush and fetch halt.
module ifu_prefetch_queue #(
  parameter int          ADDR_W   = 14,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     cpu_clk,
  input  logic                     cpu_rst,
  output logic [ADDR_W-1:0]        inst_addr,
  input  logic [31:0]              inst,
  input  logic                     fetch_en,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [31:0]              id_inst,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_pc4,
  output logic [$clog2(DEPTH):0]   q_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [31:0]   r_inst [DEPTH];
  logic [31:0]   r_pc   [DEPTH];
  logic [PW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_fetch_pc;
  logic          w_empty, w_pop, w_push;
  assign w_empty = r_count == '0;
  assign w_pop   = !w_empty && id_ready && !redirect_valid;
  // a full queue may still accept a fetch when the head leaves in the same cycle
  assign w_push  = fetch_en && !redirect_valid && (r_count != FULL || w_pop);
  assign inst_addr = r_fetch_pc[ADDR_W+1:2];
  assign id_valid  = !w_empty;
  assign id_inst   = w_empty ? '0 : r_inst[r_rd];
  assign id_pc     = w_empty ? '0 : r_pc[r_rd];
  assign id_pc4    = id_pc + 32'd4;
  assign q_count   = r_count;
  always_ff @(posedge cpu_clk or posedge cpu_rst)
    if (cpu_rst) begin
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
      r_fetch_pc <= {redirect_pc[31:2], 2'b00};
    end else begin
      if (w_pop) r_rd <= r_rd + PW'(1);
      if (w_push) begin
        r_wr       <= r_wr + PW'(1);
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_push != w_pop) r_count <= w_push ? r_count + CW'(1) : r_count - CW'(1);
    end
  always_ff @(posedge cpu_clk)
    if (w_push) begin
      r_inst[r_wr] <= inst;
      r_pc[r_wr]   <= r_fetch_pc;
    end
endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// tb_ifu_prefetch_queue: random and directed stimulus checked against a queue-based fetch model.
module tb_ifu_prefetch_queue;
  localparam int DEPTH = 4;
  logic        cpu_clk, cpu_rst;
  logic [13:0] inst_addr, w_addr;
  logic [31:0] inst, w_inst, redirect_pc;
  logic        fetch_en, redirect_valid, id_ready;
  logic        id_valid, w_valid;
  logic [31:0] id_inst, id_pc, id_pc4, w_id_inst, w_pc, w_pc4;
  logic [2:0]  q_count, w_count;
  int total = 0, bad = 0;
  logic [63:0] q[$];
  logic [31:0] m_pc;
  function automatic logic [31:0] irom(input logic [13:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction
  assign inst   = irom(inst_addr);
  assign w_inst = irom(w_addr);
  ifu_prefetch_queue #(.ADDR_W(14), .DEPTH(DEPTH), .RESET_PC(32'h0)) u_dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .inst_addr(inst_addr), .inst(inst),
    .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
    .id_pc4(id_pc4), .q_count(q_count));
  ifu_prefetch_queue #(.ADDR_W(14), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .inst_addr(w_addr), .inst(w_inst),
    .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(w_valid), .id_inst(w_id_inst), .id_pc(w_pc),
    .id_pc4(w_pc4), .q_count(w_count));
  initial cpu_clk = 0;
  always #5 cpu_clk = ~cpu_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_outputs();
    logic [63:0] h;
    h = q.size() != 0 ? q[0] : 64'h0;
    chk("valid", 32'(id_valid), 32'(q.size() != 0));
    chk("inst", id_inst, h[63:32]);
    chk("pc", id_pc, h[31:0]);
    chk("pc4", id_pc4, h[31:0] + 32'd4);
    chk("count", 32'(q_count), 32'(q.size()));
    chk("addr", 32'(inst_addr), 32'(m_pc[15:2]));
  endtask
  task automatic model_edge();
    bit pop, push;
    if (redirect_valid) begin
      q.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      pop  = q.size() != 0 && id_ready;
      push = fetch_en && (q.size() < DEPTH || pop);
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back({irom(m_pc[15:2]), m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask
  task automatic cycle(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
    fetch_en = fe;
    redirect_valid = rv;
    redirect_pc = rpc;
    id_ready = rdy;
    #1;
    check_outputs();
    @(posedge cpu_clk);
    model_edge();
    @(negedge cpu_clk);
  endtask
  task automatic do_reset();
    cpu_rst = 1;
    q.delete();
    m_pc = 32'h0;
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rst = 0;
  endtask
  initial begin
    logic [31:0] wexp [3];
    wexp[0] = 32'hFFFF_FFF8;
    wexp[1] = 32'hFFFF_FFFC;
    wexp[2] = 32'h0000_0000;
    fetch_en = 1; redirect_valid = 0; redirect_pc = 0; id_ready = 1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 1);
      chk("wrap_pc", w_pc, wexp[i]);
      chk("wrap_pc4", w_pc4, wexp[i] + 32'd4);
    end
    repeat (5) cycle(1, 0, 0, 1);
    do_reset();
    repeat (6) cycle(1, 0, 0, 0);
    chk("full_count", 32'(q_count), 32'd4);
    chk("full_addr", 32'(inst_addr), 32'd4);
    repeat (4) cycle(1, 0, 0, 1);
    do_reset();
    repeat (3) cycle(1, 0, 0, 0);
    cycle(1, 1, 32'h100, 1);
    chk("redir_addr", 32'(inst_addr), 32'h40);
    chk("redir_count", 32'(q_count), 32'd0);
    cycle(1, 0, 0, 1);
    chk("redir_pc", id_pc, 32'h100);
    chk("redir_pc4", id_pc4, 32'h104);
    repeat (2) cycle(1, 0, 0, 1);
    cycle(1, 1, 32'h103, 1);
    repeat (2) cycle(1, 0, 0, 1);
    cycle(1, 1, 32'h200, 1);
    cycle(1, 1, 32'h300, 1);
    cycle(1, 0, 0, 1);
    chk("b2b_pc", id_pc, 32'h300);
    repeat (2) cycle(1, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 1);
    chk("drain_count", 32'(q_count), 32'd0);
    cycle(0, 1, 32'h440, 1);
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 1);
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(7) != 0, $urandom_range(15) == 0,
            $urandom_range(3) == 0 ? 32'hFFFF_FFF0 | $urandom_range(15) : $urandom, $urandom_range(2) != 0);
    do_reset();
    repeat (6) cycle(1, 0, 0, 0);
    #2;
    cpu_rst = 1;
    #1;
    chk("arst_valid", 32'(id_valid), 32'd0);
    chk("arst_count", 32'(q_count), 32'd0);
    chk("arst_pc", id_pc, 32'd0);
    chk("arst_pc4", id_pc4, 32'd4);
    chk("arst_inst", id_inst, 32'd0);
    chk("arst_addr", 32'(inst_addr), 32'd0);
    chk("arst_wrap_addr", 32'(w_addr), 32'h3FFE);
    do_reset();
    repeat (3) cycle(1, 0, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
